// File: rtl/ram_rd_pkg.sv
// Shared types and sizing for the tensor-RAM burst read path.
package ram_rd_pkg;

    localparam int unsigned RD_FIFO_DEPTH = 2;
    localparam int unsigned RD_CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry {last, data} FIFO with fall-through when empty, so a word
// returning from the RAM is presented on the stream in the same cycle.
module rd_skid_fifo
    import ram_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RD_CNT_W-1:0]   count
);

    logic [DATA_WIDTH:0]  mem_q [RD_FIFO_DEPTH];
    logic [DATA_WIDTH:0]  mem_d [RD_FIFO_DEPTH];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [RD_CNT_W-1:0]  count_q, count_d;
    logic                 empty;
    logic                 store;
    logic                 take;

    // Head selection, bypass, and pointer/occupancy update
    always_comb begin
        empty     = (count_q == '0);
        out_valid = !empty || push;
        out_data  = '0;
        out_last  = 1'b0;
        if (!empty) begin
            out_data = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
            out_last = mem_q[rd_ptr_q][DATA_WIDTH];
        end else if (push) begin
            out_data = push_data;
            out_last = push_last;
        end

        take  = pop && !empty;
        // A word that bypasses straight out of an empty FIFO is never stored
        store = push && !(empty && pop) &&
                ((count_q < RD_CNT_W'(RD_FIFO_DEPTH)) || take);

        mem_d = mem_q;
        if (store) begin
            mem_d[wr_ptr_q] = {push_last, push_data};
        end
        wr_ptr_d = wr_ptr_q ^ store;
        rd_ptr_d = rd_ptr_q ^ take;
        count_d  = count_q + RD_CNT_W'(store) - RD_CNT_W'(take);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clka) begin
        if (rsta) begin
            for (int i = 0; i < int'(RD_FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator for the single-port tensor RAM: issues reads with
// credit-based pacing and streams the returned words out valid/ready.
module ram_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MEM_LENGTH = 256,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  start,
    input  logic [ADDR_SIZE-1:0]  base_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_SIZE-1:0]  ram_addra,
    input  logic [DATA_WIDTH-1:0] ram_douta,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    rd_state_t             state_q, state_d;
    logic [ADDR_SIZE-1:0]  cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    logic                  pop_c;
    logic                  room_c;
    logic                  issue_c;
    logic                  last_issue_c;
    logic                  fifo_valid;
    logic                  fifo_last;
    logic [RD_CNT_W-1:0]   fifo_count;

    rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clka      (clka),
        .rsta      (rsta),
        .push      (inflight_q),
        .push_last (inflight_last_q),
        .push_data (ram_douta),
        .pop       (pop_c),
        .out_valid (fifo_valid),
        .out_last  (fifo_last),
        .out_data  (m_data),
        .count     (fifo_count)
    );

    // Issue only if the word will still fit once it lands next cycle
    always_comb begin
        pop_c        = fifo_valid && m_ready;
        room_c       = (3'(fifo_count) + 3'(inflight_q)) < (3'(RD_FIFO_DEPTH) + 3'(pop_c));
        issue_c      = (state_q == READ) && (remain_q != '0) && room_c;
        last_issue_c = issue_c && (remain_q == LEN_WIDTH'(1));
    end

    // State register
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && (burst_len != '0)) state_d = READ;
            READ:    if (last_issue_c)               state_d = DRAIN;
            DRAIN:   if (pop_c && fifo_last)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, address/count stepping and status outputs
    always_comb begin
        cur_addr_d      = cur_addr_q;
        remain_d        = remain_q;
        inflight_d      = issue_c;
        inflight_last_d = last_issue_c;
        busy_d          = (state_d != IDLE);
        done_d          = 1'b0;

        if ((state_q == IDLE) && start) begin
            cur_addr_d = base_addr;
            remain_d   = burst_len;
            done_d     = (burst_len == '0);
        end

        if (issue_c) begin
            remain_d   = remain_q - LEN_WIDTH'(1);
            cur_addr_d = (cur_addr_q == ADDR_SIZE'(MEM_LENGTH - 1)) ? '0
                                                                   : cur_addr_q + ADDR_SIZE'(1);
        end

        if ((state_q == DRAIN) && pop_c && fifo_last) begin
            done_d = 1'b1;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clka) begin
        if (rsta) begin
            cur_addr_q      <= '0;
            remain_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            cur_addr_q      <= cur_addr_d;
            remain_q        <= remain_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_ena   = issue_c;
    assign ram_wea   = 1'b0;
    assign ram_addra = cur_addr_q;
    assign m_valid   = fifo_valid;
    assign m_last    = fifo_last;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: a preloaded RAM model, directed and random
// bursts, and a queue-based reference of the expected word stream.
module tb_ram_burst_reader;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 16;
    localparam int MEM_LEN = 16;
    localparam int LEN_W   = 16;

    logic              clka = 1'b0;
    logic              rsta;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              busy;
    logic              done;
    logic              ram_ena;
    logic              ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [DATA_W-1:0] ram_douta;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    logic [DATA_W-1:0] mem [MEM_LEN];

    int n_chk  = 0;
    int n_pass = 0;

    ram_burst_reader #(
        .ADDR_SIZE  (ADDR_W),
        .DATA_WIDTH (DATA_W),
        .MEM_LENGTH (MEM_LEN),
        .LEN_WIDTH  (LEN_W)
    ) dut (
        .clka      (clka),
        .rsta      (rsta),
        .start     (start),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_douta (ram_douta),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clka = ~clka;

    // Single-port RAM with one-cycle read latency
    always @(posedge clka) begin
        if (ram_ena === 1'b1) ram_douta <= mem[ram_addra];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        logic r;
        r = 1'b1;
        if (mode == 1) begin
            if (cyc <= 8) r = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
            else          r = 1'($urandom_range(0, 1));
        end else if (mode == 2) begin
            r = ($urandom_range(0, 9) < 4);
        end
        return r;
    endfunction

    // One burst: drive the command, watch every cycle, then score the totals.
    // restart_cyc >= 1 pulses a competing start (base 9) while busy.
    task automatic run_burst(input string name, input int base, input int len,
                             input int mode, input bit chk_time, input int restart_cyc);
        int exp_q[$];
        int ena_cnt, popped, done_cnt, first_valid, last_beat, done_cyc;
        bit addr_ok, data_ok, cap_ok, busy_ok, wea_ok;
        ena_cnt = 0; popped = 0; done_cnt = 0;
        first_valid = -1; last_beat = -1; done_cyc = -1;
        addr_ok = 1; data_ok = 1; cap_ok = 1; busy_ok = 1; wea_ok = 1;
        for (int i = 0; i < len; i++) exp_q.push_back(100 + ((base + i) % MEM_LEN));

        @(posedge clka); #1;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        burst_len = LEN_W'(len);
        m_ready   = 1'b1;

        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clka); #1;
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                base_addr = ADDR_W'(9);
                burst_len = LEN_W'(3);
            end
            m_ready = pick_ready(mode, cyc);
            #1;
            if (ram_wea !== 1'b0) wea_ok = 0;
            if (ram_ena === 1'b1) begin
                if (ram_addra !== ADDR_W'((base + ena_cnt) % MEM_LEN)) addr_ok = 0;
                ena_cnt++;
            end
            if (m_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                if (exp_q.size() == 0) begin
                    data_ok = 0;
                end else begin
                    if ((m_data !== DATA_W'(exp_q[0])) || (m_last !== (exp_q.size() == 1)))
                        data_ok = 0;
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        popped++;
                        if (exp_q.size() == 0) last_beat = cyc;
                    end
                end
            end else if (m_valid !== 1'b0) begin
                data_ok = 0;
            end
            if (ena_cnt - popped > 2) cap_ok = 0;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy !== ((done_cnt == 0) && (len > 0))) busy_ok = 0;
            if ((done_cyc >= 0) && (cyc >= done_cyc + 2)) break;
        end

        chk({name, "/ram_ena_count"}, 64'(ena_cnt), 64'(len));
        chk({name, "/beats"},         64'(popped), 64'(len));
        chk({name, "/done_pulses"},   64'(done_cnt), 64'd1);
        chk({name, "/addr_seq"},      64'(addr_ok), 64'd1);
        chk({name, "/data_last"},     64'(data_ok), 64'd1);
        chk({name, "/outstanding"},   64'(cap_ok), 64'd1);
        chk({name, "/busy"},          64'(busy_ok), 64'd1);
        chk({name, "/wea"},           64'(wea_ok), 64'd1);
        if (len > 0) chk({name, "/done_after_last"}, 64'(done_cyc), 64'(last_beat + 1));
        else         chk({name, "/done_zero_len"},   64'(done_cyc), 64'd1);
        if (chk_time && (len > 0)) begin
            chk({name, "/first_valid_cyc"}, 64'(first_valid), 64'd2);
            chk({name, "/last_beat_cyc"},   64'(last_beat), 64'(len + 1));
        end
    endtask

    initial begin
        int spurious_done;
        for (int i = 0; i < MEM_LEN; i++) mem[i] = DATA_W'(i + 100);
        rsta = 1'b1; start = 1'b0; base_addr = '0; burst_len = '0; m_ready = 1'b0;

        repeat (2) @(posedge clka);
        #2;
        chk("rst/busy",      64'(busy),      64'd0);
        chk("rst/done",      64'(done),      64'd0);
        chk("rst/ram_ena",   64'(ram_ena),   64'd0);
        chk("rst/ram_wea",   64'(ram_wea),   64'd0);
        chk("rst/ram_addra", 64'(ram_addra), 64'd0);
        chk("rst/m_valid",   64'(m_valid),   64'd0);
        chk("rst/m_data",    64'(m_data),    64'd0);
        chk("rst/m_last",    64'(m_last),    64'd0);
        rsta = 1'b0;

        run_burst("basic",   4,  5, 0, 1'b1, -1);
        run_burst("len0",    3,  0, 0, 1'b0, -1);
        run_burst("wrap",    14, 4, 0, 1'b1, -1);
        run_burst("stall",   0,  8, 1, 1'b0, -1);
        run_burst("restart", 2,  6, 0, 1'b1, 2);
        run_burst("longlen", 10, 20, 0, 1'b1, -1);
        for (int k = 0; k < 6; k++)
            run_burst("random", int'($urandom_range(0, MEM_LEN - 1)),
                      int'($urandom_range(1, 20)), 2, 1'b0, -1);

        // Reset three cycles into a long burst
        @(posedge clka); #1;
        start = 1'b1; base_addr = '0; burst_len = LEN_W'(10); m_ready = 1'b1;
        @(posedge clka); #1; start = 1'b0;
        @(posedge clka); #1;
        @(posedge clka); #1; rsta = 1'b1;
        @(posedge clka); #1; rsta = 1'b0;
        #1;
        chk("midrst/busy",      64'(busy),      64'd0);
        chk("midrst/done",      64'(done),      64'd0);
        chk("midrst/ram_ena",   64'(ram_ena),   64'd0);
        chk("midrst/ram_addra", 64'(ram_addra), 64'd0);
        chk("midrst/m_valid",   64'(m_valid),   64'd0);
        chk("midrst/m_data",    64'(m_data),    64'd0);
        chk("midrst/m_last",    64'(m_last),    64'd0);
        spurious_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clka); #2;
            if ((done !== 1'b0) || (m_valid !== 1'b0) || (busy !== 1'b0)) spurious_done++;
        end
        chk("midrst/quiet_after", 64'(spurious_done), 64'd0);
        run_burst("after_rst", 0, 2, 0, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
